axis_pattern_generator: RTL
===========================

# axis_pattern_generator

Parametrised AXI4-Stream test-pattern source with selectable pattern mode (counter, PRBS-31, walking-one, constant), a programmable sample-rate divider, credit-based buffering of sample ticks under back-pressure, TLAST framing and a dropped-sample counter. It drives one AXI4-Stream master port and serves as the stimulus source for downstream datapath bring-up and link checking.

## Interface
- DATA_WIDTH, 32, TDATA width in bits, ≥ 8, multiple of 8
- COUNTER_START, 0, counter-mode first value
- COUNTER_END, 255, counter-mode wrap threshold
- COUNTER_INCR, 1, counter-mode increment
- DIVIDER, 5, sample tick period in clocks, ≥ 1
- MAX_PENDING, 8, tick credits buffered under back-pressure, ≥ 1
- FRAME_LEN, 256, beats per frame (TLAST period), ≥ 1
- PRBS_SEED, 31'h7FFFFFFF, nonzero LFSR reset value
- CONST_VALUE, 32'hA5A5A5A5, constant-mode data (truncated/zero-extended to DATA_WIDTH)
- m_axis_aclk  in  1  clock
- m_axis_aresetn  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  gates tick generation
- mode  in  2  00 counter, 01 PRBS-31, 10 walking-one, 11 constant
- m_axis_tready  in  1  downstream ready
- m_axis_tdata  out  DATA_WIDTH  sample
- m_axis_tvalid  out  1  sample valid
- m_axis_tlast  out  1  last beat of frame
- overflow_cnt  out  16  saturating count of dropped ticks
- pending  out  $clog2(MAX_PENDING+1)  current credit count

## Operation
- Divider: down-counter, reset value DIVIDER-1, decrements every clock, reloads DIVIDER-1 at 0; free-running regardless of enable. tick = (div == 0) && enable → one tick per DIVIDER clocks while enabled.
- Credits: pending +1 on tick, −1 on output load, unchanged on both together. Tick with pending == MAX_PENDING and no load that cycle → dropped, overflow_cnt +1 (saturates at 16'hFFFF).
- Output load: when pending > 0 and (!tvalid or (tvalid && tready)) → tdata ← next sample of the mode sampled that cycle, tvalid ← 1, tlast ← (beat_idx == FRAME_LEN-1). When tvalid && tready and pending == 0 → tvalid ← 0.
- tdata/tlast stable while tvalid && !tready (AXI4-Stream rule); tvalid never withdrawn without a handshake.
- Pattern state, each advanced only on a load in its own mode:
  - counter: emits cur; next = (cur >= COUNTER_END) ? COUNTER_START : cur + COUNTER_INCR, modulo 2^DATA_WIDTH.
  - PRBS-31: x^31+x^28+1 Fibonacci, one shift per beat; emits the 31-bit state zero-extended/truncated to DATA_WIDTH.
  - walking-one: emits 1 << idx; idx wraps DATA_WIDTH-1 → 0.
  - constant: CONST_VALUE.
- beat_idx: 0..FRAME_LEN-1, increments on every load (any mode), wraps to 0.
- enable low: ticks stop; buffered credits still drain.
- Mode change affects the next load only; an in-flight beat is not altered.

## Timing
- Reset (async assert): tvalid 0, tdata 0, tlast 0, overflow_cnt 0, pending 0, beat_idx 0, counter COUNTER_START, LFSR PRBS_SEED, idx 0, divider DIVIDER-1.
- Latency: tick at cycle T → pending updates at T+1 → tvalid high from T+2, tready constantly high.
- First tick after reset release with enable high: cycle DIVIDER-1.
- Sustained throughput with tready high: one beat per DIVIDER clocks; DIVIDER = 1 gives one beat per clock with no bubbles.
- Reset mid-frame: everything returns to reset values immediately; the next frame starts at beat_idx 0.

## Structure
- Package axis_pattern_pkg: mode encoding constants (MODE_COUNTER, MODE_PRBS, MODE_WALK, MODE_CONST), PRBS taps (31, 28).
- Sub-module axis_pattern_src: holds the per-mode pattern state. Its inputs are mode and advance; its output is the next sample (combinational). Divider, credits, framing and the output register live in the top level.

## Test plan
- DIVIDER=5, mode 00, tready=1, enable=1 → tdata 0,1,2,… one beat per 5 clocks; 255 is followed by 0; tlast on beats 255, 511.
- Hold tready=0 for 60 clocks, MAX_PENDING=8 → pending reaches 8; the 4 remaining ticks are dropped (overflow_cnt=4); tdata is held stable. On release, 9 beats are emitted back-to-back with consecutive values.
- Mode 01 from reset → first beats 0x7FFFFFFF, then successive x^31+x^28+1 states matching the reference model over 1000 beats.
- Mode 10, DATA_WIDTH=8 → 01,02,…,80,01.
- Mode switch 00→11→00 mid-stream → in-flight beat unchanged; constant beats equal A5A5A5A5; the counter resumes from its held value.
- Assert reset while tvalid && !tready → all outputs are 0 immediately; after release, counter restarts at COUNTER_START and overflow_cnt is 0.

Source files
------------

// File: rtl/axis_pattern_pkg.sv
// Shared mode encoding and PRBS-31 definitions for the AXI4-Stream pattern generator.
package axis_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_COUNTER = 2'b00,
      MODE_PRBS    = 2'b01,
      MODE_WALK    = 2'b10,
      MODE_CONST   = 2'b11
   } mode_e;

   localparam int unsigned PRBS_LEN   = 31;
   localparam int unsigned PRBS_TAP_A = 31;
   localparam int unsigned PRBS_TAP_B = 28;

   // One Fibonacci shift of x^31 + x^28 + 1; feedback enters at bit 0.
   function automatic logic [PRBS_LEN-1:0] prbs_step(input logic [PRBS_LEN-1:0] s);
      return {s[PRBS_LEN-2:0], s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1]};
   endfunction

endpackage

// File: rtl/axis_pattern_src.sv
// Per-mode pattern state; presents the next sample combinationally and advances
// only the state of the currently selected mode when advance_i is high.
module axis_pattern_src
   import axis_pattern_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned COUNTER_START = 0,
   parameter int unsigned COUNTER_END   = 255,
   parameter int unsigned COUNTER_INCR  = 1,
   parameter logic [30:0] PRBS_SEED     = 31'h7FFFFFFF,
   parameter logic [31:0] CONST_VALUE   = 32'hA5A5A5A5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  mode_e                 mode_i,
   input  logic                  advance_i,
   output logic [DATA_WIDTH-1:0] sample_o
);

   localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

   localparam logic [DATA_WIDTH-1:0] CNT_START = DATA_WIDTH'(COUNTER_START);
   localparam logic [DATA_WIDTH-1:0] CNT_END   = DATA_WIDTH'(COUNTER_END);
   localparam logic [DATA_WIDTH-1:0] CNT_INCR  = DATA_WIDTH'(COUNTER_INCR);
   localparam logic [DATA_WIDTH-1:0] CONST_VAL = DATA_WIDTH'(CONST_VALUE);
   localparam logic [DATA_WIDTH-1:0] WALK_ONE  = DATA_WIDTH'(1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] cnt_q,  cnt_d;
   logic [PRBS_LEN-1:0]   lfsr_q, lfsr_d;
   logic [IDX_W-1:0]      idx_q,  idx_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= CNT_START;
         lfsr_q <= PRBS_SEED;
         idx_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         lfsr_q <= lfsr_d;
         idx_q  <= idx_d;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      lfsr_d   = lfsr_q;
      idx_d    = idx_q;
      sample_o = '0;
      case (mode_i)
         MODE_COUNTER: begin
            sample_o = cnt_q;
            if (advance_i) cnt_d = (cnt_q >= CNT_END) ? CNT_START : cnt_q + CNT_INCR;
         end
         MODE_PRBS: begin
            sample_o = DATA_WIDTH'(lfsr_q);
            if (advance_i) lfsr_d = prbs_step(lfsr_q);
         end
         MODE_WALK: begin
            sample_o = WALK_ONE << idx_q;
            if (advance_i) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
         end
         MODE_CONST: begin
            sample_o = CONST_VAL;
         end
         default: sample_o = '0;
      endcase
   end

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream test-pattern source: sample-rate divider, tick credits with drop
// counting, TLAST framing and a registered master output stage.
module axis_pattern_generator
   import axis_pattern_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned COUNTER_START = 0,
   parameter int unsigned COUNTER_END   = 255,
   parameter int unsigned COUNTER_INCR  = 1,
   parameter int unsigned DIVIDER       = 5,
   parameter int unsigned MAX_PENDING   = 8,
   parameter int unsigned FRAME_LEN     = 256,
   parameter logic [30:0] PRBS_SEED     = 31'h7FFFFFFF,
   parameter logic [31:0] CONST_VALUE   = 32'hA5A5A5A5
) (
   input  logic                               m_axis_aclk,
   input  logic                               m_axis_aresetn,
   input  logic                               enable,
   input  logic [1:0]                         mode,
   input  logic                               m_axis_tready,
   output logic [DATA_WIDTH-1:0]              m_axis_tdata,
   output logic                               m_axis_tvalid,
   output logic                               m_axis_tlast,
   output logic [15:0]                        overflow_cnt,
   output logic [$clog2(MAX_PENDING+1)-1:0]   pending
);

   localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
   localparam int unsigned DIV_W  = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam int unsigned BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(DIVIDER - 1);
   localparam logic [PEND_W-1:0] PEND_MAX   = PEND_W'(MAX_PENDING);
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(FRAME_LEN - 1);

   logic [DIV_W-1:0]      div_q,    div_d;
   logic [PEND_W-1:0]     pend_q,   pend_d;
   logic [15:0]           ovf_q,    ovf_d;
   logic [BEAT_W-1:0]     beat_q,   beat_d;
   logic [DATA_WIDTH-1:0] tdata_q,  tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q,  tlast_d;

   logic                  tick, load, drop;
   logic [DATA_WIDTH-1:0] sample;

   axis_pattern_src #(
      .DATA_WIDTH    (DATA_WIDTH),
      .COUNTER_START (COUNTER_START),
      .COUNTER_END   (COUNTER_END),
      .COUNTER_INCR  (COUNTER_INCR),
      .PRBS_SEED     (PRBS_SEED),
      .CONST_VALUE   (CONST_VALUE)
   ) u_src (
      .clk_i     (m_axis_aclk),
      .rst_ni    (m_axis_aresetn),
      .mode_i    (mode_e'(mode)),
      .advance_i (load),
      .sample_o  (sample)
   );

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         div_q    <= DIV_RELOAD;
         pend_q   <= '0;
         ovf_q    <= '0;
         beat_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         pend_q   <= pend_d;
         ovf_q    <= ovf_d;
         beat_q   <= beat_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
      end
   end

   // A load is allowed whenever the output slot is empty or is being consumed this cycle.
   always_comb begin
      tick  = (div_q == '0) && enable;
      load  = (pend_q != '0) && (!tvalid_q || m_axis_tready);
      drop  = tick && !load && (pend_q == PEND_MAX);
      div_d = (div_q == '0) ? DIV_RELOAD : div_q - DIV_W'(1);

      pend_d = pend_q;
      if (tick && !load && !drop) pend_d = pend_q + PEND_W'(1);
      else if (load && !tick)     pend_d = pend_q - PEND_W'(1);

      ovf_d = ovf_q;
      if (drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;

      beat_d   = beat_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      if (load) begin
         tdata_d  = sample;
         tvalid_d = 1'b1;
         tlast_d  = (beat_q == BEAT_LAST);
         beat_d   = (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
      end else if (tvalid_q && m_axis_tready) begin
         tvalid_d = 1'b0;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign overflow_cnt  = ovf_q;
   assign pending       = pend_q;

endmodule
